// File: rtl/func_result_logger.sv
// ----------------------------------------------------------------------------
// func_result_logger
//
// Purpose:
//   Downstream stage of the 5-input / 4-output combinational function block.
//   Registers the input vector {A..E} and the result {F1..F4} every cycle,
//   detects changes in F1..F4 between enabled samples, and logs each change
//   as {[ts], A..E, F1..F4} into a first-word-fall-through FIFO that a
//   consumer drains over a valid/ready handshake.
//
// Configuration macro:
//   FRL_TIMESTAMP_EN - when defined, a TS_W-bit free-running counter is
//                      kept and every entry carries the counter value of its
//                      compare cycle in out_data[8+TS_W:9]. When undefined,
//                      out_data is 9 bits and TS_W is unused.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-high reset
//   in_vec      in   [4:0] {A,B,C,D,E}, A = bit 4
//   f_in        in   [3:0] {F1,F2,F3,F4}, F1 = bit 3
//   capture_en  in   1 = sample and compare this cycle
//   out_valid   out  FIFO head valid
//   out_ready   in   consumer accepts head
//   out_data    out  head entry {[ts], in_vec, f}; 0 when FIFO empty
//   count       out  entries stored, 0..DEPTH
//   overflow    out  sticky, an entry was dropped because the FIFO was full
//   clr_ovf     in   clears overflow (a simultaneous drop wins)
//
// Parameters:
//   DEPTH       FIFO entries, power of 2, >= 2
//   TS_W        timestamp width (only with FRL_TIMESTAMP_EN)
// ----------------------------------------------------------------------------
module func_result_logger #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [4:0]               in_vec,
    input  logic [3:0]               f_in,
    input  logic                     capture_en,
    output logic                     out_valid,
    input  logic                     out_ready,
`ifdef FRL_TIMESTAMP_EN
    output logic [TS_W+8:0]          out_data,
`else
    output logic [8:0]               out_data,
`endif
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef FRL_TIMESTAMP_EN
    localparam int DW = TS_W + 9;
`else
    localparam int DW = 9;
`endif
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Stage 1 registers
    logic [4:0]    r_in_q;
    logic [3:0]    r_f_q;
    logic          r_en_q;

    // Stage 2 change-detection state
    logic [3:0]    r_prev_f;
    logic          r_prev_valid;

    // FIFO storage and bookkeeping
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_wr;
    logic          w_drop;
    logic [DW-1:0] w_entry;

    // ------------------------------------------------------------------
    // Stage 1 and stage 2 registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_q       <= '0;
            r_f_q        <= '0;
            r_en_q       <= 1'b0;
            r_prev_f     <= '0;
            r_prev_valid <= 1'b0;
        end else begin
            r_in_q <= in_vec;
            r_f_q  <= f_in;
            r_en_q <= capture_en;
            // The reference follows every enabled sample, even when the
            // resulting entry is dropped on a full FIFO.
            if (r_en_q) begin
                r_prev_f     <= r_f_q;
                r_prev_valid <= 1'b1;
            end
        end
    end

    // The first enabled sample after reset always logs (no reference yet).
    assign w_push = r_en_q & (~r_prev_valid | (r_f_q != r_prev_f));

`ifdef FRL_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    // r_ts here is the value during the compare cycle of this entry.
    assign w_entry = {r_ts, r_in_q, r_f_q};
`else
    logic w_unused_ts;
    assign w_unused_ts = (TS_W > 0);
    assign w_entry     = {r_in_q, r_f_q};
`endif

    // ------------------------------------------------------------------
    // FWFT FIFO
    // Handshake: out_valid is high exactly while the FIFO holds an entry and
    // out_data shows the head; a pop happens on an edge where out_valid and
    // out_ready are both high. out_valid only falls after a pop, out_data is
    // held while out_valid & !out_ready, and out_ready is ignored while
    // out_valid is low.
    // ------------------------------------------------------------------
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & out_ready;
    // A pop in the same cycle frees the slot, so a push on a full FIFO
    // still succeeds when the head is taken.
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + CW'(w_wr) - CW'(w_pop);
            // A new drop has priority over a clear in the same cycle.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Storage needs no reset: out_data is masked to 0 while empty.
    always_ff @(posedge clk) begin
        if (w_wr && !rst) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    assign out_valid = ~w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rptr];
    assign count     = r_count;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_func_result_logger.sv
// ----------------------------------------------------------------------------
// tb_func_result_logger
//
// Directed bench for func_result_logger (DEPTH=8). Inputs are driven 1 time
// unit after a rising edge and outputs are sampled at the same point, i.e.
// they show the state produced by that edge.
// ----------------------------------------------------------------------------
module tb_func_result_logger;

    localparam int DEPTH = 8;
    localparam int TS_W  = 8;

    // ------------------------------------------------------------------
    // Clock / reset and DUT
    // ------------------------------------------------------------------
    logic        clk;
    logic        rst;
    logic [4:0]  in_vec;
    logic [3:0]  f_in;
    logic        capture_en;
    logic        out_valid;
    logic        out_ready;
`ifdef FRL_TIMESTAMP_EN
    logic [TS_W+8:0] out_data;
`else
    logic [8:0]      out_data;
`endif
    logic [3:0]  count;
    logic        overflow;
    logic        clr_ovf;

    int checks   = 0;
    int failures = 0;

    // Scoreboard of expected {in_vec, f} entries, in FIFO order
    logic [8:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    func_result_logger #(
        .DEPTH (DEPTH),
        .TS_W  (TS_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_vec     (in_vec),
        .f_in       (f_in),
        .capture_en (capture_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .count      (count),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    // ------------------------------------------------------------------
    // Driver / checker tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [3:0] exp_cnt,
                               input logic exp_valid, input logic [8:0] exp_data);
        check({tag, "_count"}, 32'(count), 32'(exp_cnt));
        check({tag, "_valid"}, 32'(out_valid), 32'(exp_valid));
        check({tag, "_data"},  32'(out_data[8:0]), 32'(exp_data));
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        logic [8:0] e;

        rst        = 1'b1;
        in_vec     = '0;
        f_in       = '0;
        capture_en = 1'b0;
        out_ready  = 1'b0;
        clr_ovf    = 1'b0;
        ticks(2);

        // Reset state
        check_state("reset", 4'd0, 1'b0, 9'h000);
        check("reset_ovf", 32'(overflow), 32'd0);

        // 1: first enabled sample after reset logs exactly once
        capture_en = 1'b1;
        in_vec     = 5'b11000;
        f_in       = 4'b1000;
        rst        = 1'b0;
        tick();
        check_state("t1_edge1", 4'd0, 1'b0, 9'h000);
        tick();
        check_state("t1_edge2", 4'd1, 1'b1, 9'h188);
        ticks(3);
        check_state("t1_hold", 4'd1, 1'b1, 9'h188);

        // 2: f held at 0101 while in_vec walks 0..31 -> only the change logs
        for (int i = 0; i < 32; i++) begin
            in_vec = 5'(i);
            f_in   = 4'b0101;
            tick();
        end
        ticks(2);
        check_state("t2_walk", 4'd2, 1'b1, 9'h188);
        out_ready = 1'b1;
        tick();
        check_state("t2_pop1", 4'd1, 1'b1, 9'h005);
        tick();
        check_state("t2_pop2", 4'd0, 1'b0, 9'h000);
        tick();
        check_state("t2_ready_empty", 4'd0, 1'b0, 9'h000);
        out_ready = 1'b0;

        // 3: nine distinct changes into an 8-deep FIFO with no consumer
        for (int k = 1; k <= 9; k++) begin
            in_vec = 5'(k);
            f_in   = 4'(k);
            tick();
            if (k <= DEPTH) exp_q.push_back({5'(k), 4'(k)});
        end
        ticks(2);
        check_state("t3_full", 4'd8, 1'b1, 9'h011);
        check("t3_ovf_set", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t3_ovf_clr", 32'(overflow), 32'd0);
        check("t3_count_after_clr", 32'(count), 32'd8);

        // 4: full FIFO, pop and push on the same edge
        in_vec = 5'd10;
        f_in   = 4'hA;
        tick();
        e = exp_q.pop_front();
        check("t4_head_before", 32'(out_data[8:0]), 32'(e));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_q.push_back(9'h0AA);
        check("t4_count", 32'(count), 32'd8);
        check("t4_ovf", 32'(overflow), 32'd0);
        tick();
        check("t4_count_hold", 32'(count), 32'd8);
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("t4_drain", 32'(out_data[8:0]), 32'(e));
            tick();
        end
        out_ready = 1'b0;
        check_state("t4_empty", 4'd0, 1'b0, 9'h000);

        // 5: disabled capture ignores toggles; re-enable with same f logs nothing
        capture_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            f_in = (i % 2 == 0) ? 4'h3 : 4'hC;
            tick();
        end
        ticks(2);
        check_state("t5_disabled", 4'd0, 1'b0, 9'h000);
        f_in       = 4'hA;
        capture_en = 1'b1;
        ticks(3);
        check_state("t5_reenable", 4'd0, 1'b0, 9'h000);

        // 6: reset with three entries queued
        in_vec = 5'd0;
        for (int k = 1; k <= 3; k++) begin
            f_in = 4'(k);
            tick();
        end
        ticks(2);
        check_state("t6_queued", 4'd3, 1'b1, 9'h001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_state("t6_reset", 4'd0, 1'b0, 9'h000);
        ticks(2);
        check_state("t6_first_after", 4'd1, 1'b1, 9'h003);
`ifdef FRL_TIMESTAMP_EN
        check("t6_ts", 32'(out_data[TS_W+8:9]), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
